// File: rtl/rr_arbiter4_pkg.sv
// Shared definitions for the four-way round-robin arbiter: state encoding and sizes.
package rr_arbiter4_pkg;

  localparam int N_REQ = 4;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } arb_state_e;

  // Requester that follows idx in the circular priority order.
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return idx + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
// The lock signal exists only when ARB_LOCK_EN is defined.
interface rr_arbiter4_if;

  logic [rr_arbiter4_pkg::N_REQ-1:0] req;
  logic [rr_arbiter4_pkg::N_REQ-1:0] gnt;
  logic [1:0]                        gnt_idx;
  logic                              gnt_valid;
  logic                              timeout_o;
`ifdef ARB_LOCK_EN
  logic                              lock;

  modport master (output req, lock, input gnt, gnt_idx, gnt_valid, timeout_o);
  modport slave  (input req, lock, output gnt, gnt_idx, gnt_valid, timeout_o);
`else
  modport master (output req, input gnt, gnt_idx, gnt_valid, timeout_o);
  modport slave  (input req, output gnt, gnt_idx, gnt_valid, timeout_o);
`endif

endinterface

// File: rtl/rr_arbiter4_dec.sv
// Gate-level 2-to-4 decoder with enable; every output is driven low when disabled.
module arb_grant_dec (
  input  logic [1:0] idx,
  input  logic       en,
  output logic [3:0] dec
);

  logic [1:0] idx_n;

  not u_inv0 (idx_n[0], idx[0]);
  not u_inv1 (idx_n[1], idx[1]);

  for (genvar gi = 0; gi < 4; gi++) begin : g_out
    localparam logic [1:0] CODE = 2'(gi);
    logic sel0;
    logic sel1;
    assign sel0 = CODE[0] ? idx[0] : idx_n[0];
    assign sel1 = CODE[1] ? idx[1] : idx_n[1];
    and u_and (dec[gi], en, sel1, sel0);
  end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with bounded hold time and a turnaround cycle.
// Define ARB_LOCK_EN to add a lock input that suspends the hold timeout.
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int TIMEOUT  = 15,
  parameter int PTR_INIT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  rr_arbiter4_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e       state_reg;
  logic [1:0]       idx_reg;
  logic [1:0]       ptr_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             valid_reg;
  logic             timeout_reg;

  logic [N_REQ-1:0] rot;
  logic [1:0]       win_off;
  logic [1:0]       win_next;
  logic             win_found;
  logic             lock_act;

`ifdef ARB_LOCK_EN
  assign lock_act = bus.lock;
`else
  assign lock_act = 1'b0;
`endif

  // Rotate requests so that bit 0 is the requester currently holding top priority.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
    assign rot[gi] = bus.req[ptr_reg + 2'(gi)];
  end

  always_comb begin
    win_off = 2'd0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        win_off = 2'(k);
      end
    end
    win_found = |rot;
    win_next  = ptr_reg + win_off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      idx_reg     <= 2'b00;
      ptr_reg     <= 2'(PTR_INIT);
      cnt_reg     <= '0;
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            idx_reg   <= win_next;
            valid_reg <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          // A dropped request wins over a coincident timeout: that is a normal release.
          if (!bus.req[idx_reg]) begin
            state_reg <= RELEASE;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
            ptr_reg   <= next_idx(idx_reg);
          end else if (!lock_act && cnt_reg == CNT_LAST) begin
            state_reg   <= RELEASE;
            valid_reg   <= 1'b0;
            cnt_reg     <= '0;
            ptr_reg     <= next_idx(idx_reg);
            timeout_reg <= 1'b1;
          end else if (!lock_act) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RELEASE: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  arb_grant_dec u_dec (
    .idx (idx_reg),
    .en  (valid_reg),
    .dec (bus.gnt)
  );

  assign bus.gnt_idx   = idx_reg;
  assign bus.gnt_valid = valid_reg;
  assign bus.timeout_o = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4 (TIMEOUT=4, PTR_INIT=2) with a grant-ownership model
// checked every cycle; the lock scenario runs only when ARB_LOCK_EN is defined.
module tb_rr_arbiter4;

  localparam int TO = 4;
  localparam int PI = 2;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_bad;
  bit   mon_en;
  bit   mon_prev_v;

  rr_arbiter4_if bus ();

  rr_arbiter4 #(.TIMEOUT(TO), .PTR_INIT(PI)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic lock_now;
`ifdef ARB_LOCK_EN
  assign lock_now = bus.lock;
`else
  assign lock_now = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: who owns the resource, for how long, and whether a cool-down cycle is pending.
  typedef struct packed {
    int owner;
    int age;
    int ptr;
    bit cool;
    bit to;
  } mstate_t;

  mstate_t m;

  function automatic mstate_t model_next(mstate_t s, logic [3:0] r, logic lk);
    mstate_t n;
    n    = s;
    n.to = 1'b0;
    if (s.owner >= 0) begin
      if (!r[s.owner]) begin
        n.owner = -1; n.cool = 1'b1; n.age = 0; n.ptr = (s.owner + 1) % 4;
      end else if (!lk && s.age == TO - 1) begin
        n.owner = -1; n.cool = 1'b1; n.age = 0; n.ptr = (s.owner + 1) % 4; n.to = 1'b1;
      end else if (!lk) begin
        n.age = s.age + 1;
      end
    end else if (s.cool) begin
      n.cool = 1'b0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (n.owner < 0 && r[(s.ptr + k) % 4]) begin
          n.owner = (s.ptr + k) % 4;
          n.age   = 0;
        end
      end
    end
    return n;
  endfunction

  function automatic int exp_gnt(mstate_t s);
    return (s.owner >= 0) ? (1 << s.owner) : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '{owner: -1, age: 0, ptr: PI, cool: 1'b0, to: 1'b0};
    else        m <= model_next(m, bus.req, lock_now);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("m_gnt", int'(bus.gnt), exp_gnt(m));
      chk("m_valid", int'(bus.gnt_valid), int'(m.owner >= 0));
      chk("m_timeout", int'(bus.timeout_o), int'(m.to));
      if (m.owner >= 0) chk("m_idx", int'(bus.gnt_idx), m.owner);
      chk("m_onehot", int'($countones(bus.gnt) <= 1), 1);
      if (bus.gnt_valid && !mon_prev_v)
        $display("grant: idx=%0d req=%b t=%0t", bus.gnt_idx, bus.req, $time);
      mon_prev_v <= bus.gnt_valid;
    end
  end

  int run, pulses, phase, held, gap, started;
  int order[$];
  logic [3:0] drop;

  initial begin
    n_total = 0; n_bad = 0; mon_en = 1'b0; mon_prev_v = 1'b0;
    rst_n = 1'b0; bus.req = 4'b0000;
`ifdef ARB_LOCK_EN
    bus.lock = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_valid", int'(bus.gnt_valid), 0);
    chk("rst_idx", int'(bus.gnt_idx), 0);
    chk("rst_timeout", int'(bus.timeout_o), 0);
    rst_n = 1'b1; mon_en = 1'b1;

    // Single request: grant one edge later, then a zero-grant RELEASE cycle.
    bus.req = 4'b0100;
    @(negedge clk);
    chk("single_gnt", int'(bus.gnt), 4'b0100);
    chk("single_idx", int'(bus.gnt_idx), 2);
    chk("single_valid", int'(bus.gnt_valid), 1);
    bus.req = 4'b0000;
    @(negedge clk);
    chk("single_rel_gnt", int'(bus.gnt), 0);
    chk("single_rel_valid", int'(bus.gnt_valid), 0);
    @(negedge clk);
    chk("single_idle_gnt", int'(bus.gnt), 0);
    $display("single request done t=%0t", $time);

    // Rotation: all request, each grantee drops for one cycle after 3 grant cycles.
    // Pointer is 3 after the single-request grant to 2.
    bus.req = 4'b1111; held = 0; gap = 0; started = 0; order.delete();
    for (int c = 0; c < 80 && order.size() < 5; c++) begin
      @(negedge clk);
      if (bus.gnt_valid && held == 0) begin
        order.push_back(int'(bus.gnt_idx));
        if (started != 0) chk("rot_gap", gap, 2);
        started = 1; gap = 0;
      end
      if (bus.gnt_valid) held++;
      else begin held = 0; gap++; end
      drop = (bus.gnt_valid && held == 3) ? (4'b0001 << bus.gnt_idx) : 4'b0000;
      bus.req = 4'b1111 & ~drop;
    end
    chk("rot_count", order.size(), 5);
    if (order.size() == 5) begin
      chk("rot_0", order[0], 3); chk("rot_1", order[1], 0); chk("rot_2", order[2], 1);
      chk("rot_3", order[3], 2); chk("rot_4", order[4], 3);
    end
    bus.req = 4'b0000;
    repeat (4) @(negedge clk);
    $display("rotation done t=%0t", $time);

    // Timeout with a single requester: 4 grant cycles, one pulse, then re-grant.
    bus.req = 4'b0001; run = 0; pulses = 0; phase = 0;
    for (int c = 0; c < 30 && phase < 2; c++) begin
      @(negedge clk);
      if (bus.timeout_o) pulses++;
      if (phase == 0 && bus.gnt == 4'b0001) run++;
      else if (phase == 0 && run > 0) begin
        phase = 1;
        chk("to_pulse_on_release", int'(bus.timeout_o), 1);
      end else if (phase == 1 && bus.gnt == 4'b0001) phase = 2;
    end
    chk("to_run", run, 4);
    chk("to_pulses", pulses, 1);
    chk("to_regrant", phase, 2);
    bus.req = 4'b0000;
    repeat (4) @(negedge clk);
    $display("timeout done t=%0t", $time);

    // Fairness after timeout: pointer is 1, so grants go 1,0,1,0.
    bus.req = 4'b0011; pulses = 0; order.delete(); mon_prev_v = 1'b0;
    held = 0;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      @(negedge clk);
      if (bus.timeout_o) pulses++;
      if (bus.gnt_valid && held == 0) order.push_back(int'(bus.gnt_idx));
      held = bus.gnt_valid ? held + 1 : 0;
    end
    chk("fair_count", order.size(), 4);
    chk("fair_pulses", pulses, 3);
    if (order.size() == 4) begin
      chk("fair_0", order[0], 1); chk("fair_1", order[1], 0);
      chk("fair_2", order[2], 1); chk("fair_3", order[3], 0);
    end
    bus.req = 4'b0000;
    repeat (4) @(negedge clk);
    $display("fairness done t=%0t", $time);

    // Drop coincides with the timeout cycle: normal release, no pulse. Pointer is 1.
    bus.req = 4'b0001;
    repeat (4) @(negedge clk);
    chk("coinc_gnt", int'(bus.gnt), 4'b0001);
    bus.req = 4'b0000;
    @(negedge clk);
    chk("coinc_gnt_rel", int'(bus.gnt), 0);
    chk("coinc_timeout", int'(bus.timeout_o), 0);
    repeat (2) @(negedge clk);
    $display("coincident drop done t=%0t", $time);

    // Asynchronous reset mid-grant, then pointer back at PTR_INIT.
    bus.req = 4'b0010;
    @(negedge clk);
    chk("arst_pre_gnt", int'(bus.gnt), 4'b0010);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_gnt", int'(bus.gnt), 0);
    chk("arst_valid", int'(bus.gnt_valid), 0);
    @(negedge clk);
    rst_n = 1'b1; bus.req = 4'b1111;
    @(negedge clk);
    chk("arst_first_gnt", int'(bus.gnt), 4'b0100);
    chk("arst_first_idx", int'(bus.gnt_idx), PI);
    bus.req = 4'b0000;
    repeat (3) @(negedge clk);
    $display("async reset done t=%0t", $time);

`ifdef ARB_LOCK_EN
    // Lock holds the grant for 10 cycles; revocation 4 cycles after it drops.
    bus.req = 4'b0001; bus.lock = 1'b1;
    @(negedge clk);
    chk("lock_gnt_first", int'(bus.gnt), 4'b0001);
    for (int k = 1; k < 10; k++) begin
      @(negedge clk);
      chk("lock_gnt_held", int'(bus.gnt), 4'b0001);
      chk("lock_no_timeout", int'(bus.timeout_o), 0);
    end
    bus.lock = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("unlock_gnt_held", int'(bus.gnt), 4'b0001);
    end
    @(negedge clk);
    chk("unlock_revoked", int'(bus.gnt), 0);
    chk("unlock_timeout", int'(bus.timeout_o), 1);
    bus.req = 4'b0000;
    repeat (3) @(negedge clk);
    $display("lock done t=%0t", $time);
`endif

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
